secded_encoder_tx: RTL and testbench



---
 rtl/secded_encoder_tx.sv | 188 ++++++++++++++++++
 tb/tb_secded_encoder_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/secded_encoder_tx.sv
// -----------------------------------------------------------------------------
// secded_encoder_tx
//
// Purpose:
//   Upstream half of the oscillator-control SECDED link. Accepts 8-bit data
//   words over a valid/ready handshake and buffers them in a small circular
//   FIFO. It encodes each word into a 13-bit extended-Hamming code word and
//   presents it on a registered valid/ready output.
//
// Build option:
//   SECDED_ERR_INJECT_EN - when defined, inj_arm captures inj_mask. The next
//   output-register load XORs that mask into the code word. When undefined,
//   the inj_* inputs are ignored and inj_armed is tied low.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of the transmitted-word counter
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   in_data     data word to encode
//   in_valid    in_data valid
//   in_ready    block can accept a word (FIFO not full)
//   out_code    encoded 13-bit code word (registered)
//   out_valid   out_code valid
//   out_ready   downstream accepts out_code
//   inj_mask    bit-flip mask for the next loaded code word
//   inj_arm     one-cycle pulse that captures inj_mask
//   inj_armed   an injection is pending
//   word_count  completed output handshakes (wraps)
//   fifo_level  current FIFO occupancy
// -----------------------------------------------------------------------------
module secded_encoder_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [12:0]                out_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [12:0]                inj_mask,
  input  logic                       inj_arm,
  output logic                       inj_armed,
  output logic [CNT_W-1:0]           word_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Extended Hamming(13,8): data sits at the non-power-of-two positions.
  // Bit 0 carries even parity over the whole word.
  function automatic logic [12:0] secded_encode(input logic [7:0] d);
    logic [12:0] c;
    c      = '0;
    c[3]   = d[0];
    c[5]   = d[1];
    c[6]   = d[2];
    c[7]   = d[3];
    c[9]   = d[4];
    c[10]  = d[5];
    c[11]  = d[6];
    c[12]  = d[7];
    c[1]   = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2]   = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4]   = c[5] ^ c[6] ^ c[7] ^ c[12];
    c[8]   = c[9] ^ c[10] ^ c[11] ^ c[12];
    c[0]   = ^c[12:1];
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    level_next;

  logic [12:0]      code_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg;

  logic             push;
  logic             load;
  logic             fifo_empty;
  logic [12:0]      inj_apply;

  assign fifo_empty = (level_reg == '0);
  // Ready depends on full only: a pop in the same cycle does not open a slot.
  assign in_ready   = (level_reg != LW'(DEPTH));
  assign push       = in_valid && in_ready;
  // The output register refills whenever it is empty or being drained.
  assign load       = !fifo_empty && (!valid_reg || out_ready);

  always_comb begin
    level_next = level_reg;
    case ({push, load})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Storage has no reset so it maps onto plain RAM. The pointers and level
  // define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // The pointers are AW bits wide, so they wrap at DEPTH with no extra logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Error injection
  // ---------------------------------------------------------------------------
`ifdef SECDED_ERR_INJECT_EN
  logic [12:0] mask_reg;
  logic        armed_reg;

  // A load consumes the arm that was pending before this edge. A coincident
  // arm wins, so it stays pending for the following load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg  <= '0;
      armed_reg <= 1'b0;
    end else if (inj_arm) begin
      mask_reg  <= inj_mask;
      armed_reg <= 1'b1;
    end else if (load) begin
      armed_reg <= 1'b0;
    end
  end

  assign inj_apply = armed_reg ? mask_reg : 13'd0;
  assign inj_armed = armed_reg;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_mask, inj_arm};
  assign inj_apply  = 13'd0;
  assign inj_armed  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output register and handshake counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code_reg  <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      if (load) begin
        code_reg  <= secded_encode(mem[rd_ptr_reg]) ^ inj_apply;
        valid_reg <= 1'b1;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
      if (valid_reg && out_ready) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign out_code   = code_reg;
  assign out_valid  = valid_reg;
  assign word_count = count_reg;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_secded_encoder_tx.sv
module tb_secded_encoder_tx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic              clock;
  logic              reset_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [12:0]       out_code;
  logic              out_valid;
  logic              out_ready;
  logic [12:0]       inj_mask;
  logic              inj_arm;
  logic              inj_armed;
  logic [CNT_W-1:0]  word_count;
  logic [2:0]        fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  secded_encoder_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inj_mask   (inj_mask),
    .inj_arm    (inj_arm),
    .inj_armed  (inj_armed),
    .word_count (word_count),
    .fifo_level (fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    inj_arm   = 1'b0;
    inj_mask  = 13'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_code !== 13'h0000) begin n_fail++; $display("FAIL reset_out_code got=%h exp=0000", out_code); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_checks++; if (word_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", word_count); end
    n_checks++; if (inj_armed !== 1'b0) begin n_fail++; $display("FAIL reset_inj_armed got=%b exp=0", inj_armed); end
    $display("reset: out_valid=%b level=%0d in_ready=%b", out_valid, fifo_level, in_ready);
  endtask

  // 0x00, 0x01, 0xFF streamed with out_ready high.
  task automatic test_basic_encode();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got=%b exp=0", out_valid); end
    in_data = 8'h01;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_code !== 13'h0000) begin n_fail++; $display("FAIL basic_00 got=%b/%h exp=1/0000", out_valid, out_code); end
    $display("tx data=00 code=%h", out_code);
    in_data = 8'hFF;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_code !== 13'h000F) begin n_fail++; $display("FAIL basic_01 got=%b/%h exp=1/000f", out_valid, out_code); end
    $display("tx data=01 code=%h", out_code);
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_code !== 13'h1EEE) begin n_fail++; $display("FAIL basic_ff got=%b/%h exp=1/1eee", out_valid, out_code); end
    $display("tx data=ff code=%h", out_code);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    n_checks++; if (word_count !== 4'd3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", word_count); end
  endtask

  // Stall the output. 0x11 is held in the output register and 0x12..0x15
  // fill the FIFO. The sixth word must wait.
  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 + 8'(i);
      tick();
    end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_code !== 13'h030C) begin n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/030c", out_valid, out_code); end
    in_data = 8'h16;
    tick();
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_no_accept got=%0d exp=4", fifo_level); end
    n_checks++; if (out_code !== 13'h030C) begin n_fail++; $display("FAIL bp_stable got=%h exp=030c", out_code); end
    $display("stall: holding code=%h level=%0d", out_code, fifo_level);
  endtask

  // Full FIFO with pop and push requested together: only the pop happens.
  task automatic test_full_pop();
    logic [12:0] exp_seq [3];
    exp_seq[0] = 13'h033F;
    exp_seq[1] = 13'h0356;
    exp_seq[2] = 13'h0359;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h16;
    tick();
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL full_pop_level got=%0d exp=3", fifo_level); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_code !== 13'h0330) begin n_fail++; $display("FAIL drain_12 got=%b/%h exp=1/0330", out_valid, out_code); end
    $display("tx data=12 code=%h", out_code);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_code !== exp_seq[i]) begin n_fail++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i + 3, out_valid, out_code, exp_seq[i]); end
      $display("tx data=%h code=%h", 8'h13 + 8'(i), out_code);
    end
    tick();
    n_checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL drain_end got=%b/%0d exp=0/0", out_valid, fifo_level); end
    n_checks++; if (word_count !== 4'd8) begin n_fail++; $display("FAIL drain_count got=%0d exp=8", word_count); end
  endtask

  // Reset mid-cycle while words are buffered; outputs must clear before any edge.
  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h21 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got=%0d/%b exp=3/1", fifo_level, out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_code !== 13'h0000) begin n_fail++; $display("FAIL arst_out got=%b/%h exp=0/0000", out_valid, out_code); end
    n_checks++; if (fifo_level !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_fifo got=%0d/%b exp=0/1", fifo_level, in_ready); end
    n_checks++; if (word_count !== 4'd0) begin n_fail++; $display("FAIL arst_count got=%0d exp=0", word_count); end
    $display("async reset: out_valid=%b level=%0d", out_valid, fifo_level);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_code !== 13'h000F) begin n_fail++; $display("FAIL arst_after got=%b/%h exp=1/000f", out_valid, out_code); end
    $display("tx data=01 code=%h", out_code);
    tick();
  endtask

  task automatic test_inject();
    logic        exp_armed;
    logic [12:0] exp_first;
`ifdef SECDED_ERR_INJECT_EN
    exp_armed = 1'b1;
    exp_first = 13'h000B;
`else
    exp_armed = 1'b0;
    exp_first = 13'h000F;
`endif
    do_reset();
    inj_mask = 13'h0004;
    inj_arm  = 1'b1;
    tick();
    inj_arm  = 1'b0;
    inj_mask = 13'h1FFF;
    n_checks++; if (inj_armed !== exp_armed) begin n_fail++; $display("FAIL inj_armed_set got=%b exp=%b", inj_armed, exp_armed); end
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    n_checks++; if (inj_armed !== exp_armed) begin n_fail++; $display("FAIL inj_armed_hold got=%b exp=%b", inj_armed, exp_armed); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_code !== exp_first) begin n_fail++; $display("FAIL inj_first got=%b/%h exp=1/%h", out_valid, out_code, exp_first); end
    n_checks++; if (inj_armed !== 1'b0) begin n_fail++; $display("FAIL inj_armed_clear got=%b exp=0", inj_armed); end
    $display("tx data=01 code=%h (injection)", out_code);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_code !== 13'h000F) begin n_fail++; $display("FAIL inj_second got=%b/%h exp=1/000f", out_valid, out_code); end
    $display("tx data=01 code=%h", out_code);
    tick();
  endtask

  // 16 handshakes on a 4-bit counter: 15 then back to 0.
  task automatic test_count_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (word_count !== 4'd15) begin n_fail++; $display("FAIL wrap_15 got=%0d exp=15", word_count); end
    tick();
    n_checks++; if (word_count !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_0 got=%0d/%b exp=0/0", word_count, out_valid); end
    $display("count wrap: word_count=%0d after 16 words", word_count);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    inj_arm   = 1'b0;
    inj_mask  = 13'd0;
    #1;
    test_reset();
    test_basic_encode();
    test_backpressure();
    test_full_pop();
    test_async_reset();
    test_inject();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
